// File: rtl/fifo_axis_reader_pkg.sv
// Shared constants and helpers for the sync_fifo to AXI-Stream reader.
package fifo_axis_reader_pkg;

   localparam int BUF_DEPTH = 3;
   localparam int OCC_W     = 2;
   localparam int PKT_CNT_W = 16;

   typedef logic [OCC_W-1:0] occ_t;

   // Words held or already promised to the output buffer.
   function automatic logic [2:0] fill_level(input occ_t occ, input logic rd_pend);
      return {1'b0, occ} + {2'b00, rd_pend};
   endfunction

endpackage

// File: rtl/axis_out_buf.sv
// Three-entry ordered output buffer: push at tail, pop at head, head always visible.
module axis_out_buf
   import fifo_axis_reader_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output occ_t         occ,
   output logic [W-1:0] head
);

   localparam logic [1:0] LAST_PTR = 2'(BUF_DEPTH - 1);

   logic [W-1:0] mem [BUF_DEPTH];
   logic [1:0]   rd_ptr;
   logic [1:0]   wr_ptr;
   logic         pop_ok;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   // Popping an empty buffer is ignored so occ cannot underflow.
   assign pop_ok = pop & (occ != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop_ok})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a sync_fifo into an AXI-Stream master, framing fixed-length packets with tlast.
module fifo_axis_reader
   import fifo_axis_reader_pkg::*;
#(
   parameter int FIFO_WIDTH = 32,
   parameter int PKT_LEN    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic [FIFO_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [PKT_CNT_W-1:0]  pkt_count
);

   localparam logic [15:0] WCNT_LAST = 16'(PKT_LEN - 1);

   occ_t        occ;
   logic        rd_pend;
   logic [15:0] wcnt;
   logic        xfer;

   // Handshake: a word moves when m_axis_tvalid & m_axis_tready at a rising edge;
   // tvalid depends only on registered occupancy, so tdata/tvalid hold until taken.
   // Reads are gated on registered fill only, keeping tready out of the fifo_rd_en path.
   assign fifo_rd_en    = ~fifo_empty & ~reset & (fill_level(occ, rd_pend) <= 3'd2);
   assign m_axis_tvalid = (occ != '0);
   assign m_axis_tlast  = m_axis_tvalid & (wcnt == WCNT_LAST);
   assign xfer          = m_axis_tvalid & m_axis_tready;

   axis_out_buf #(.W(FIFO_WIDTH)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_pend),
      .push_data (fifo_dout),
      .pop       (xfer),
      .occ       (occ),
      .head      (m_axis_tdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend   <= 1'b0;
         wcnt      <= '0;
         pkt_count <= '0;
      end else begin
         rd_pend <= fifo_rd_en;
         if (xfer) begin
            wcnt <= (wcnt == WCNT_LAST) ? 16'd0 : wcnt + 16'd1;
            if (m_axis_tlast) pkt_count <= pkt_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: behavioural sync_fifo sources, stream monitors, scenario tasks.
module tb_fifo_axis_reader;

   localparam int W     = 32;
   localparam int PKT_A = 16;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic         rd_en_a, empty_a, tvalid_a, tready_a, tlast_a;
   logic [W-1:0] dout_a, tdata_a;
   logic [15:0]  pkts_a;
   logic         rd_en_b, empty_b, tvalid_b, tready_b, tlast_b;
   logic [W-1:0] dout_b, tdata_b;
   logic [15:0]  pkts_b;

   fifo_axis_reader #(.FIFO_WIDTH(W), .PKT_LEN(PKT_A)) dut_a (
      .clk(clk), .reset(reset), .fifo_rd_en(rd_en_a), .fifo_dout(dout_a), .fifo_empty(empty_a),
      .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
      .m_axis_tlast(tlast_a), .pkt_count(pkts_a)
   );

   fifo_axis_reader #(.FIFO_WIDTH(W), .PKT_LEN(1)) dut_b (
      .clk(clk), .reset(reset), .fifo_rd_en(rd_en_b), .fifo_dout(dout_b), .fifo_empty(empty_b),
      .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
      .m_axis_tlast(tlast_b), .pkt_count(pkts_b)
   );

   // Upstream sync_fifo models: data appears on dout one cycle after an accepted read.
   logic [W-1:0] mem_a [DEPTH];
   logic [W-1:0] mem_b [DEPTH];
   int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

   assign empty_a = (rd_a == wr_a);
   assign empty_b = (rd_b == wr_b);

   always @(posedge clk) begin
      if (flush) begin
         rd_a <= wr_a;
         rd_b <= wr_b;
      end else begin
         if (rd_en_a && rd_a != wr_a) begin dout_a <= mem_a[rd_a]; rd_a <= rd_a + 1; end
         if (rd_en_b && rd_b != wr_b) begin dout_b <= mem_b[rd_b]; rd_b <= rd_b + 1; end
      end
   end

   // Stream monitors
   logic [W-1:0] got_d[$];
   bit           got_l[$];
   int           got_c[$];
   int           rd_c[$];
   logic [W-1:0] got_bd[$];
   bit           got_bl[$];
   int           viol_empty = 0, viol_stable = 0, viol_ovf = 0;
   bit           pv = 1'b0;
   logic [W-1:0] pd;

   always @(posedge clk) begin
      if (rd_en_a) rd_c.push_back(cyc);
      if ((rd_en_a && empty_a) || (rd_en_b && empty_b)) viol_empty++;
      if (!reset && pv && (!tvalid_a || tdata_a !== pd)) viol_stable++;
      if (!reset && dut_a.rd_pend && dut_a.occ == 2'd3 && !(tvalid_a && tready_a)) viol_ovf++;
      if (!reset && tvalid_a && tready_a) begin
         got_d.push_back(tdata_a); got_l.push_back(tlast_a); got_c.push_back(cyc);
      end
      if (!reset && tvalid_b && tready_b) begin
         got_bd.push_back(tdata_b); got_bl.push_back(tlast_b);
      end
      pv = !reset && tvalid_a && !tready_a;
      pd = tdata_a;
   end

   // Reference model: words leave in push order; every PKT_A-th word since reset ends a packet.
   logic [W-1:0] exp_q[$];
   int tests_run = 0, tests_failed = 0;
   int widx = 0, exp_pkts = 0;

   task automatic model_reset();
      exp_q.delete(); widx = 0; exp_pkts = 0;
   endtask

   task automatic model_next(output logic [W-1:0] e, output bit el);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      el = ((widx + 1) % PKT_A) == 0;
      widx++;
      if (el) exp_pkts++;
   endtask

   task automatic push_a(input logic [W-1:0] d);
      mem_a[wr_a] = d; wr_a++; exp_q.push_back(d);
   endtask

   task automatic clear_mon();
      got_d.delete(); got_l.delete(); got_c.delete(); rd_c.delete();
   endtask

   task automatic wait_got(input int n, input int budget, output bit ok);
      int k = 0;
      while (got_d.size() < n && k < budget) begin @(negedge clk); k++; end
      ok = (got_d.size() >= n);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b1; flush = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0; flush = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b1; tready_a = 1'b0; tready_b = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (tvalid_a !== 1'b0 || tlast_a !== 1'b0 || rd_en_a !== 1'b0 || pkts_a !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_a: tvalid=%b tlast=%b rd_en=%b pkts=%0d, want all 0", tvalid_a, tlast_a, rd_en_a, pkts_a);
      end
      tests_run++;
      if (tvalid_b !== 1'b0 || tlast_b !== 1'b0 || rd_en_b !== 1'b0 || pkts_b !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_b: tvalid=%b tlast=%b rd_en=%b pkts=%0d, want all 0", tvalid_b, tlast_b, rd_en_b, pkts_b);
      end
      reset = 1'b0; flush = 1'b0;
      model_reset();
      @(negedge clk);
      tests_run++;
      if (rd_en_a !== 1'b0 || tvalid_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_empty: rd_en=%b tvalid=%b, want 0 0", rd_en_a, tvalid_a);
      end
   endtask

   task automatic test_throughput();
      bit ok; logic [W-1:0] e; bit el; bit seq_ok;
      clear_mon();
      tready_a = 1'b1;
      for (int i = 0; i < 40; i++) push_a($urandom);
      wait_got(40, 200, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL tput_count: got %0d words, want 40", got_d.size()); end
      seq_ok = (rd_c.size() == 40);
      for (int i = 0; seq_ok && i < 40; i++) if (rd_c[i] != rd_c[0] + i) seq_ok = 1'b0;
      tests_run++;
      if (!seq_ok) begin tests_failed++; $display("FAIL tput_reads: %0d reads not back-to-back, want 40 consecutive", rd_c.size()); end
      seq_ok = ok && rd_c.size() > 0;
      for (int i = 0; seq_ok && i < 40; i++) if (got_c[i] != rd_c[0] + 2 + i) seq_ok = 1'b0;
      tests_run++;
      if (!seq_ok) begin tests_failed++; $display("FAIL tput_valid: transfers not continuous from read+2"); end
      for (int i = 0; i < got_d.size() && i < 40; i++) begin
         model_next(e, el);
         tests_run++;
         if (got_d[i] !== e || got_l[i] !== el) begin
            tests_failed++;
            $display("FAIL tput_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], e, el);
         end
      end
      tests_run++;
      if (pkts_a !== 16'(exp_pkts)) begin tests_failed++; $display("FAIL tput_pkts: got %0d, want %0d", pkts_a, exp_pkts); end
   endtask

   task automatic test_stall();
      bit ok; logic [W-1:0] e; bit el;
      clear_mon();
      tready_a = 1'b0;
      for (int i = 0; i < 8; i++) push_a($urandom);
      repeat (20) @(negedge clk);
      tests_run++;
      if (rd_c.size() != 3 || dut_a.occ !== 2'd3 || rd_en_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_reads: reads=%0d occ=%0d rd_en=%b, want 3 3 0", rd_c.size(), dut_a.occ, rd_en_a);
      end
      tests_run++;
      if (tvalid_a !== 1'b1 || tdata_a !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL stall_head: tvalid=%b tdata=%h, want 1 %h", tvalid_a, tdata_a, exp_q[0]);
      end
      tready_a = 1'b1;
      wait_got(8, 100, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL stall_count: got %0d words, want 8", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 8; i++) begin
         model_next(e, el);
         tests_run++;
         if (got_d[i] !== e || got_l[i] !== el) begin
            tests_failed++;
            $display("FAIL stall_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], e, el);
         end
      end
   endtask

   task automatic test_toggle();
      logic [W-1:0] e; bit el; int k = 0;
      clear_mon();
      for (int i = 0; i < 32; i++) push_a($urandom);
      while (got_d.size() < 32 && k < 300) begin tready_a = ~tready_a; @(negedge clk); k++; end
      tready_a = 1'b1;
      repeat (5) @(negedge clk);
      tests_run++;
      if (got_d.size() != 32) begin tests_failed++; $display("FAIL toggle_count: got %0d words, want 32", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 32; i++) begin
         model_next(e, el);
         tests_run++;
         if (got_d[i] !== e || got_l[i] !== el) begin
            tests_failed++;
            $display("FAIL toggle_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], e, el);
         end
      end
      tests_run++;
      if (viol_stable != 0 || viol_ovf != 0) begin
         tests_failed++;
         $display("FAIL toggle_stable: stable_viol=%0d ovf=%0d, want 0 0", viol_stable, viol_ovf);
      end
      tests_run++;
      if (pkts_a !== 16'(exp_pkts)) begin tests_failed++; $display("FAIL toggle_pkts: got %0d, want %0d", pkts_a, exp_pkts); end
   endtask

   task automatic test_sparse();
      bit ok; logic [W-1:0] e; bit el; int k;
      clear_mon();
      tready_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(1, 6)) @(negedge clk);
         push_a($urandom);
         k = 0;
         while (!empty_a && k < 10) begin @(negedge clk); k++; end
      end
      wait_got(20, 50, ok);
      tests_run++;
      if (!ok || viol_empty != 0) begin
         tests_failed++;
         $display("FAIL sparse_flow: words=%0d empty_reads=%0d, want 20 0", got_d.size(), viol_empty);
      end
      for (int i = 0; i < got_d.size() && i < 20; i++) begin
         model_next(e, el);
         tests_run++;
         if (got_d[i] !== e || got_l[i] !== el) begin
            tests_failed++;
            $display("FAIL sparse_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], e, el);
         end
      end
   endtask

   task automatic test_mid_reset();
      bit ok; logic [W-1:0] e; bit el;
      do_reset(2);
      clear_mon();
      tready_a = 1'b1;
      for (int i = 0; i < 21; i++) push_a($urandom);
      wait_got(21, 100, ok);
      for (int i = 0; i < got_d.size() && i < 21; i++) model_next(e, el);
      tests_run++;
      if (!ok || pkts_a !== 16'd1) begin
         tests_failed++;
         $display("FAIL mid_pre: words=%0d pkts=%0d, want 21 1", got_d.size(), pkts_a);
      end
      tready_a = 1'b0;
      for (int i = 0; i < 10; i++) push_a($urandom);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (tvalid_a !== 1'b0 || tlast_a !== 1'b0 || rd_en_a !== 1'b0 || pkts_a !== 16'd0 || empty_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: tvalid=%b tlast=%b rd_en=%b pkts=%0d empty=%b, want 0 0 0 0 0",
                  tvalid_a, tlast_a, rd_en_a, pkts_a, empty_a);
      end
      flush = 1'b1;
      @(negedge clk);
      reset = 1'b0; flush = 1'b0;
      model_reset();
      clear_mon();
      tready_a = 1'b1;
      for (int i = 0; i < 16; i++) push_a($urandom);
      wait_got(16, 100, ok);
      repeat (5) @(negedge clk);
      tests_run++;
      if (got_d.size() != 16) begin tests_failed++; $display("FAIL mid_count: got %0d words, want 16", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 16; i++) begin
         model_next(e, el);
         tests_run++;
         if (got_d[i] !== e || got_l[i] !== el) begin
            tests_failed++;
            $display("FAIL mid_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], e, el);
         end
      end
      tests_run++;
      if (pkts_a !== 16'(exp_pkts)) begin tests_failed++; $display("FAIL mid_pkts: got %0d, want %0d", pkts_a, exp_pkts); end
   endtask

   task automatic test_pkt1();
      logic [W-1:0] exp_b[$]; logic [W-1:0] d; int k = 0;
      tready_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = $urandom; mem_b[wr_b] = d; wr_b++; exp_b.push_back(d);
      end
      while (got_bd.size() < 4 && k < 50) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      tests_run++;
      if (got_bd.size() != 4) begin tests_failed++; $display("FAIL pkt1_count: got %0d words, want 4", got_bd.size()); end
      for (int i = 0; i < got_bd.size() && i < 4; i++) begin
         tests_run++;
         if (got_bd[i] !== exp_b[i] || got_bl[i] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pkt1_word%0d: got %h last=%b, want %h last=1", i, got_bd[i], got_bl[i], exp_b[i]);
         end
      end
      tests_run++;
      if (pkts_b !== 16'd4) begin tests_failed++; $display("FAIL pkt1_pkts: got %0d, want 4", pkts_b); end
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_stall();
      test_toggle();
      test_sparse();
      test_mid_reset();
      test_pkt1();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
